pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised program-counter unit.
- Next generation of the 16-bit inc/add/sub PC: generic width and step, absolute jump, call/return through an internal return-address stack (RAS), stall, and sticky stack-error flags.
- Sits in the fetch stage. Drives the instruction-memory address. Takes control strobes from the decoder.

Parameters:
- WIDTH, 16: PC and offset/target width in bits.
- RAS_DEPTH, 4: number of return-address stack entries (>=2).
- RESET_VEC, 0: PC value loaded on reset.
- STEP, 1: increment applied by inc and used as the call return offset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  freeze: no PC or stack change this cycle.
- inc  input  1  pc <= pc + STEP.
- add  input  1  pc <= pc + offset.
- sub  input  1  pc <= pc - offset.
- jump  input  1  pc <= target.
- call  input  1  push pc + STEP; pc <= target.
- ret  input  1  pc <= top of stack; pop.
- offset  input  WIDTH  relative displacement for add/sub.
- target  input  WIDTH  absolute address for jump/call.
- pc  output  WIDTH  current program counter (registered).
- ras_count  output  $clog2(RAS_DEPTH+1)  valid stack entries.
- ras_full  output  1  ras_count == RAS_DEPTH.
- ras_empty  output  1  ras_count == 0.
- err_overflow  output  1  sticky: a call was made while full.
- err_underflow  output  1  sticky: a ret was made while empty.

Behaviour:
- Reset (async, any time, including mid-operation):
  - pc = RESET_VEC; ras_count = 0; err flags = 0.
  - Stack contents are don't-care.
  - Operation resumes on the first rising edge after deassertion.
- All state updates on the rising clk edge. One-cycle latency: strobes sampled at edge N appear on pc after edge N.
- stall = 1 overrides everything: pc, stack and flags hold.
- Priority when several strobes are high: ret > call > jump > sub > add > inc. Only the winner takes effect.
- No strobe: pc holds.
- Arithmetic: modulo 2^WIDTH, no carry/borrow output. Examples: 0xFFFF + 1 = 0x0000; 0x0000 - 1 = 0xFFFF.
- call, not full:
  - stack[top] <= pc + STEP (mod 2^WIDTH); ras_count += 1; pc <= target.
- call, full:
  - Circular overwrite: the oldest entry is discarded and the new return address becomes top.
  - ras_count stays RAS_DEPTH; pc <= target; err_overflow <= 1.
- ret, not empty: pc <= top entry; ras_count -= 1.
- ret, empty: pc holds; ras_count stays 0; err_underflow <= 1.
- ras_full and ras_empty are combinational decodes of ras_count.
- Err flags stay set until reset.
- Stack implementation: circular buffer with a write pointer mod RAS_DEPTH plus ras_count. Top = ptr - 1 mod RAS_DEPTH.

Decomposition:
- Shared package pc_pkg:
  - Op-select encoding localparams: OP_NONE, OP_INC, OP_ADD, OP_SUB, OP_JUMP, OP_CALL, OP_RET.
  - Priority-encode function mapping the strobes to an op.
- Sub-module ras_stack:
  - Parameters WIDTH and RAS_DEPTH.
  - Inputs push, pop, push_data.
  - Outputs top_data, count, full, empty.
  - Implements the overwrite-on-full and ignore-on-empty rules.
  - Reports overflow/underflow pulses to pc_unit, which holds the sticky flags.
- pc_unit contains the priority decode, next-PC mux/adder and PC register.

Test Plan:
1. Reset, then inc for 3 cycles -> pc 0x0000, 0x0001, 0x0002, 0x0003. Then add with offset 0x00A5 -> 0x00A8. Then sub with offset 0x0014 -> 0x0094.
2. From pc 0x0094: call with target 0x0200 -> pc 0x0200, ras_count 1. Then call with target 0x0300 -> pc 0x0300, count 2. Then ret -> 0x0201. Then ret -> 0x0095, ras_empty = 1.
3. Wrap: jump to 0xFFFF, then inc -> 0x0000. Then sub with offset 0x0001 -> 0xFFFF.
4. RAS_DEPTH = 4: five calls from pc values A0..A4 -> err_overflow = 1, count 4. Then four rets return A4+1, A3+1, A2+1, A1+1. A fifth ret -> pc holds, err_underflow = 1.
5. Priority and stall:
   - inc+add+ret together with count 1 and top 0x0040 -> pc 0x0040.
   - jump+inc with target 0x1234 -> pc 0x1234.
   - stall with call -> pc, count and stack all unchanged.
6. Reset mid-call sequence (count 2, pc 0x0300), asserted between edges -> pc 0x0000 immediately, count 0, flags 0. A ret after deassert -> err_underflow = 1.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: operation encoding and
// the strobe priority encoder used to pick a single winning operation.
package pc_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_NONE = 3'd0;
    localparam op_t OP_INC  = 3'd1;
    localparam op_t OP_ADD  = 3'd2;
    localparam op_t OP_SUB  = 3'd3;
    localparam op_t OP_JUMP = 3'd4;
    localparam op_t OP_CALL = 3'd5;
    localparam op_t OP_RET  = 3'd6;

    // Highest priority first: ret > call > jump > sub > add > inc.
    function automatic op_t priority_op(
        input logic inc,
        input logic add,
        input logic sub,
        input logic jump,
        input logic call,
        input logic ret
    );
        op_t op;
        op = OP_NONE;
        if (ret)       op = OP_RET;
        else if (call) op = OP_CALL;
        else if (jump) op = OP_JUMP;
        else if (sub)  op = OP_SUB;
        else if (add)  op = OP_ADD;
        else if (inc)  op = OP_INC;
        return op;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Return-address stack built as a circular buffer. A push while full
// overwrites the oldest entry; a pop while empty changes nothing. Both
// misuse cases are reported as single-cycle pulses to the owner.
module ras_stack #(
    parameter int WIDTH     = 16,
    parameter int RAS_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               push_data,
    output logic [WIDTH-1:0]               top_data,
    output logic [$clog2(RAS_DEPTH+1)-1:0] count,
    output logic                           full,
    output logic                           empty,
    output logic                           overflow,
    output logic                           underflow
);

    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(RAS_DEPTH - 1);

    logic [WIDTH-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    top_ptr;
    logic [PW-1:0]    next_ptr;
    logic             do_push;

    // A pop wins if both arrive together; the owner never issues both.
    assign do_push   = push && !pop;
    assign full      = (count == CW'(RAS_DEPTH));
    assign empty     = (count == '0);
    assign overflow  = do_push && full;
    assign underflow = pop && empty;

    // Pointer arithmetic wraps explicitly so non-power-of-two depths work.
    assign top_ptr   = (wr_ptr == '0) ? LAST_PTR : wr_ptr - 1'b1;
    assign next_ptr  = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
    assign top_data  = mem[top_ptr];

    // Write pointer and occupancy; when full the pointer still advances,
    // which makes the slot holding the oldest entry the next one written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (pop) begin
            if (!empty) begin
                wr_ptr <= top_ptr;
                count  <= count - 1'b1;
            end
        end else if (push) begin
            wr_ptr <= next_ptr;
            if (!full) begin
                count <= count + 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only read below the valid count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: picks one operation from the decoder strobes,
// computes the next PC (modulo 2^WIDTH) and manages call/return through the
// return-address stack, with sticky overflow/underflow flags.
module pc_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter int               RAS_DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter logic [WIDTH-1:0] STEP      = WIDTH'(1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           stall,
    input  logic                           inc,
    input  logic                           add,
    input  logic                           sub,
    input  logic                           jump,
    input  logic                           call,
    input  logic                           ret,
    input  logic [WIDTH-1:0]               offset,
    input  logic [WIDTH-1:0]               target,
    output logic [WIDTH-1:0]               pc,
    output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
    output logic                           ras_full,
    output logic                           ras_empty,
    output logic                           err_overflow,
    output logic                           err_underflow
);

    op_t              op;
    logic [WIDTH-1:0] pc_plus_step;
    logic [WIDTH-1:0] next_pc;
    logic [WIDTH-1:0] top_data;
    logic             push;
    logic             pop;
    logic             overflow;
    logic             underflow;

    assign op           = priority_op(inc, add, sub, jump, call, ret);
    assign pc_plus_step = pc + STEP;

    // Stall freezes the stack too, so push/pop are gated here.
    assign push = !stall && (op == OP_CALL);
    assign pop  = !stall && (op == OP_RET);

    ras_stack #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (pc_plus_step),
        .top_data  (top_data),
        .count     (ras_count),
        .full      (ras_full),
        .empty     (ras_empty),
        .overflow  (overflow),
        .underflow (underflow)
    );

    // Next-PC selection; a return with nothing stacked leaves the PC alone.
    always_comb begin
        next_pc = pc;
        case (op)
            OP_INC:  next_pc = pc_plus_step;
            OP_ADD:  next_pc = pc + offset;
            OP_SUB:  next_pc = pc - offset;
            OP_JUMP: next_pc = target;
            OP_CALL: next_pc = target;
            OP_RET:  next_pc = ras_empty ? pc : top_data;
            default: next_pc = pc;
        endcase
    end

    // PC register and sticky error flags, all frozen while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc            <= RESET_VEC;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else if (!stall) begin
            pc <= next_pc;
            if (overflow) begin
                err_overflow <= 1'b1;
            end
            if (underflow) begin
                err_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit with hand-computed expected values.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        inc, add, sub, jump, call, ret;
    logic [15:0] offset, target;
    logic [15:0] pc;
    logic [2:0]  ras_count;
    logic        ras_full, ras_empty, err_overflow, err_underflow;

    int errors = 0;
    int checks = 0;

    localparam logic [5:0] S_NONE = 6'b000000;
    localparam logic [5:0] S_INC  = 6'b000001;
    localparam logic [5:0] S_ADD  = 6'b000010;
    localparam logic [5:0] S_SUB  = 6'b000100;
    localparam logic [5:0] S_JUMP = 6'b001000;
    localparam logic [5:0] S_CALL = 6'b010000;
    localparam logic [5:0] S_RET  = 6'b100000;

    pc_unit #(
        .WIDTH     (16),
        .RAS_DEPTH (4),
        .RESET_VEC (16'h0000),
        .STEP      (16'h0001)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .inc           (inc),
        .add           (add),
        .sub           (sub),
        .jump          (jump),
        .call          (call),
        .ret           (ret),
        .offset        (offset),
        .target        (target),
        .pc            (pc),
        .ras_count     (ras_count),
        .ras_full      (ras_full),
        .ras_empty     (ras_empty),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Compare one observed value against its expectation.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Hold the strobes across one rising edge, then release them 1 unit later.
    task automatic applyStimulus(input logic [5:0] strobes, input logic stl,
                                 input logic [15:0] off, input logic [15:0] tgt);
        {ret, call, jump, sub, add, inc} = strobes;
        stall  = stl;
        offset = off;
        target = tgt;
        @(posedge clk);
        #1;
        {ret, call, jump, sub, add, inc} = S_NONE;
        stall = 1'b0;
    endtask

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        {ret, call, jump, sub, add, inc} = S_NONE;
        offset = '0;
        target = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_pc",    32'(pc), 32'h0000);
        checkOutput("reset_count", 32'(ras_count), 32'd0);
        checkOutput("reset_empty", 32'(ras_empty), 32'd1);
        checkOutput("reset_full",  32'(ras_full), 32'd0);
        checkOutput("reset_errs",  32'({err_overflow, err_underflow}), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("idle_hold", 32'(pc), 32'h0000);

        // Basic arithmetic
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(S_INC, 1'b0, 16'h0000, 16'h0000);
            checkOutput("inc", 32'(pc), 32'(i));
        end
        applyStimulus(S_ADD, 1'b0, 16'h00A5, 16'h0000);
        checkOutput("add", 32'(pc), 32'h00A8);
        applyStimulus(S_SUB, 1'b0, 16'h0014, 16'h0000);
        checkOutput("sub", 32'(pc), 32'h0094);

        // Nested call/return
        applyStimulus(S_CALL, 1'b0, 16'h0000, 16'h0200);
        checkOutput("call1_pc", 32'(pc), 32'h0200);
        checkOutput("call1_cnt", 32'(ras_count), 32'd1);
        applyStimulus(S_CALL, 1'b0, 16'h0000, 16'h0300);
        checkOutput("call2_pc", 32'(pc), 32'h0300);
        checkOutput("call2_cnt", 32'(ras_count), 32'd2);
        applyStimulus(S_RET, 1'b0, 16'h0000, 16'h0000);
        checkOutput("ret1_pc", 32'(pc), 32'h0201);
        applyStimulus(S_RET, 1'b0, 16'h0000, 16'h0000);
        checkOutput("ret2_pc", 32'(pc), 32'h0095);
        checkOutput("ret2_empty", 32'(ras_empty), 32'd1);

        // Wrap-around
        applyStimulus(S_JUMP, 1'b0, 16'h0000, 16'hFFFF);
        checkOutput("jump_ffff", 32'(pc), 32'hFFFF);
        applyStimulus(S_INC, 1'b0, 16'h0000, 16'h0000);
        checkOutput("inc_wrap", 32'(pc), 32'h0000);
        applyStimulus(S_SUB, 1'b0, 16'h0001, 16'h0000);
        checkOutput("sub_wrap", 32'(pc), 32'hFFFF);

        // Overflow: calls from A0..A4 push A1..A5; the fifth overwrites A1
        applyStimulus(S_JUMP, 1'b0, 16'h0000, 16'h00A0);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(S_CALL, 1'b0, 16'h0000, 16'(16'h00A0 + i));
        end
        checkOutput("full_cnt", 32'(ras_count), 32'd4);
        checkOutput("full_flag", 32'(ras_full), 32'd1);
        checkOutput("no_ovf_yet", 32'(err_overflow), 32'd0);
        applyStimulus(S_CALL, 1'b0, 16'h0000, 16'h0500);
        checkOutput("ovf_pc", 32'(pc), 32'h0500);
        checkOutput("ovf_flag", 32'(err_overflow), 32'd1);
        checkOutput("ovf_cnt", 32'(ras_count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(S_RET, 1'b0, 16'h0000, 16'h0000);
            checkOutput("ovf_ret", 32'(pc), 32'(16'h00A5 - i));
        end
        checkOutput("drain_empty", 32'(ras_empty), 32'd1);
        checkOutput("no_unf_yet", 32'(err_underflow), 32'd0);
        applyStimulus(S_RET, 1'b0, 16'h0000, 16'h0000);
        checkOutput("unf_pc", 32'(pc), 32'h00A2);
        checkOutput("unf_flag", 32'(err_underflow), 32'd1);
        checkOutput("unf_cnt", 32'(ras_count), 32'd0);
        checkOutput("ovf_sticky", 32'(err_overflow), 32'd1);

        // Priority: set up one entry holding 0x0040
        applyStimulus(S_JUMP, 1'b0, 16'h0000, 16'h003F);
        applyStimulus(S_CALL, 1'b0, 16'h0000, 16'h0100);
        checkOutput("prio_setup", 32'(pc), 32'h0100);
        applyStimulus(S_INC | S_ADD | S_RET, 1'b0, 16'h0005, 16'h0000);
        checkOutput("prio_ret", 32'(pc), 32'h0040);
        checkOutput("prio_ret_cnt", 32'(ras_count), 32'd0);
        applyStimulus(S_JUMP | S_INC, 1'b0, 16'h0000, 16'h1234);
        checkOutput("prio_jump", 32'(pc), 32'h1234);
        applyStimulus(S_SUB | S_ADD | S_INC, 1'b0, 16'h0004, 16'h0000);
        checkOutput("prio_sub", 32'(pc), 32'h1230);

        // Stall holds PC and stack
        applyStimulus(S_CALL, 1'b0, 16'h0000, 16'h2000);
        applyStimulus(S_CALL, 1'b1, 16'h0000, 16'h0777);
        checkOutput("stall_pc", 32'(pc), 32'h2000);
        checkOutput("stall_cnt", 32'(ras_count), 32'd1);
        applyStimulus(S_INC, 1'b1, 16'h0000, 16'h0000);
        checkOutput("stall_inc", 32'(pc), 32'h2000);
        applyStimulus(S_RET, 1'b0, 16'h0000, 16'h0000);
        checkOutput("stall_stack", 32'(pc), 32'h1231);

        // Asynchronous reset in the middle of a call sequence
        applyStimulus(S_JUMP, 1'b0, 16'h0000, 16'h0100);
        applyStimulus(S_CALL, 1'b0, 16'h0000, 16'h0200);
        applyStimulus(S_CALL, 1'b0, 16'h0000, 16'h0300);
        checkOutput("pre_rst_pc", 32'(pc), 32'h0300);
        checkOutput("pre_rst_cnt", 32'(ras_count), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("arst_pc", 32'(pc), 32'h0000);
        checkOutput("arst_cnt", 32'(ras_count), 32'd0);
        checkOutput("arst_errs", 32'({err_overflow, err_underflow}), 32'd0);
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(S_RET, 1'b0, 16'h0000, 16'h0000);
        checkOutput("arst_ret_pc", 32'(pc), 32'h0000);
        checkOutput("arst_unf", 32'(err_underflow), 32'd1);
        checkOutput("arst_ovf", 32'(err_overflow), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
